// File: rtl/ps2_keys_pkg.sv
// rtl/ps2_keys_pkg.sv - scancode constants, state enum and JIS character mapping
package ps2_keys_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_NONE   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_BRK, ST_EXT, ST_EXTBRK, ST_EMIT, ST_CLEAR
  } state_t;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
      8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
      8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
      8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
      8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
      8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
      8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
      8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
      8'h35: return 8'h79;  8'h1A: return 8'h7A;
      8'h4E: return 8'h2D;  8'h55: return 8'h5E;  8'h6A: return 8'h5C;
      8'h51: return 8'h5C;  8'h54: return 8'h40;  8'h5B: return 8'h5B;
      8'h4C: return 8'h3B;  8'h52: return 8'h3A;  8'h5D: return 8'h5D;
      8'h41: return 8'h2C;  8'h49: return 8'h2E;  8'h4A: return 8'h2F;
      8'h29: return 8'h20;
      default: return CH_NONE;
    endcase
  endfunction

  // Shifted glyph on a JIS keyboard is a fixed offset per ASCII column
  function automatic logic [7:0] jis_shift(input logic [7:0] ch);
    case (ch[7:4])
      4'h2:       return ch + 8'h10;
      4'h3:       return ch - 8'h10;
      4'h4, 4'h5: return ch + 8'h20;
      4'h6, 4'h7: return ch - 8'h20;
      default:    return ch;
    endcase
  endfunction

endpackage

// File: rtl/ps2_line_editor_if.sv
// rtl/ps2_line_editor_if.sv - scan byte input and LCD write handshake bundle
interface ps2_line_editor_if #(parameter int AW = 4) ();
  logic          scan_valid;
  logic [7:0]    scan_code;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;

  modport master (input scan_valid, scan_code, wr_ready,
                  output wr_en, wr_addr, wr_data);
  modport slave  (output scan_valid, scan_code, wr_ready,
                  input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ps2_line_editor_decoder.sv
// rtl/ps2_line_editor_decoder.sv - ps2_key_decoder: prefix FSM, shift/caps tracking, key events
module ps2_key_decoder
  import ps2_keys_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       busy,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       shift_on,
  output logic       caps_on
);

  state_t state, state_next;
  logic   shift_l, shift_r;
  logic   take;

  // Bytes arriving while the editor is busy are dropped without touching prefix state
  assign take     = scan_valid && !busy;
  assign shift_on = shift_l | shift_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (take) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)    state_next = ST_BRK;
          else if (scan_code == SC_EXT) state_next = ST_EXT;
        end
        ST_EXT:  state_next = (scan_code == SC_BREAK) ? ST_EXTBRK : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_valid = 1'b0;
    key_ext   = 1'b0;
    key_code  = scan_code;
    if (take) begin
      if (state == ST_IDLE && scan_code != SC_BREAK && scan_code != SC_EXT)
        key_valid = 1'b1;
      if (state == ST_EXT && scan_code != SC_BREAK) begin
        key_valid = 1'b1;
        key_ext   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      caps_on <= 1'b0;
    end else if (take) begin
      if (state == ST_IDLE) begin
        if (scan_code == SC_LSHIFT) shift_l <= 1'b1;
        if (scan_code == SC_RSHIFT) shift_r <= 1'b1;
        if (scan_code == SC_CAPS)   caps_on <= ~caps_on;
      end else if (state == ST_BRK) begin
        if (scan_code == SC_LSHIFT) shift_l <= 1'b0;
        if (scan_code == SC_RSHIFT) shift_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_line_editor.sv
// rtl/ps2_line_editor.sv - line editor core: cursor, single-cell writes and line clear
module ps2_line_editor
  import ps2_keys_pkg::*;
#(
  parameter int COLS = 16,
  parameter int AW   = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_line_editor_if.master     bus,
  output logic [AW-1:0]         cursor,
  output logic                  shift_on,
  output logic                  caps_on,
  output logic                  drop
);

  localparam logic [AW-1:0] LAST = AW'(COLS - 1);

  state_t        mode, mode_next;
  logic          busy, key_valid, key_ext, is_letter;
  logic [7:0]    key_code, ascii, glyph;
  logic          emit_adv, adv_n, wr_en_n, drop_n;
  logic [AW-1:0] cursor_n, wr_addr_n;
  logic [7:0]    wr_data_n;

  assign busy = (mode != ST_IDLE);

  ps2_key_decoder u_decoder (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (bus.scan_valid),
    .scan_code  (bus.scan_code),
    .busy       (busy),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .shift_on   (shift_on),
    .caps_on    (caps_on)
  );

  always_comb begin
    ascii     = scan_to_ascii(key_code);
    is_letter = (ascii >= 8'h61) && (ascii <= 8'h7A);
    if (is_letter) glyph = (shift_on ^ caps_on) ? ascii - 8'h20 : ascii;
    else           glyph = shift_on ? jis_shift(ascii) : ascii;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode <= ST_IDLE;
    else       mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    case (mode)
      ST_IDLE: begin
        if (key_valid && !key_ext) begin
          if (key_code == SC_ENTER)                   mode_next = ST_CLEAR;
          else if (key_code == SC_BKSP && cursor != '0) mode_next = ST_EMIT;
          else if (key_code != SC_BKSP && ascii != CH_NONE) mode_next = ST_EMIT;
        end
      end
      ST_EMIT:  if (bus.wr_ready) mode_next = ST_IDLE;
      ST_CLEAR: if (bus.wr_ready && bus.wr_addr == LAST) mode_next = ST_IDLE;
      default:  mode_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cursor_n  = cursor;
    wr_en_n   = bus.wr_en;
    wr_addr_n = bus.wr_addr;
    wr_data_n = bus.wr_data;
    adv_n     = emit_adv;
    drop_n    = bus.scan_valid && busy;
    case (mode)
      ST_IDLE: begin
        if (key_valid && key_ext) begin
          if (key_code == SC_LEFT && cursor != '0)    cursor_n = cursor - AW'(1);
          if (key_code == SC_RIGHT && cursor != LAST) cursor_n = cursor + AW'(1);
        end else if (key_valid) begin
          if (key_code == SC_ENTER) begin
            wr_en_n   = 1'b1;
            wr_addr_n = '0;
            wr_data_n = CH_SPACE;
          end else if (key_code == SC_BKSP) begin
            if (cursor != '0) begin
              cursor_n  = cursor - AW'(1);
              wr_en_n   = 1'b1;
              wr_addr_n = cursor - AW'(1);
              wr_data_n = CH_SPACE;
              adv_n     = 1'b0;
            end
          end else if (ascii != CH_NONE) begin
            wr_en_n   = 1'b1;
            wr_addr_n = cursor;
            wr_data_n = glyph;
            adv_n     = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (bus.wr_ready) begin
          wr_en_n = 1'b0;
          if (emit_adv) cursor_n = (cursor == LAST) ? '0 : cursor + AW'(1);
        end
      end
      ST_CLEAR: begin
        if (bus.wr_ready) begin
          if (bus.wr_addr == LAST) begin
            wr_en_n  = 1'b0;
            cursor_n = '0;
          end else begin
            wr_addr_n = bus.wr_addr + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor      <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= CH_SPACE;
      emit_adv    <= 1'b0;
      drop        <= 1'b0;
    end else begin
      cursor      <= cursor_n;
      bus.wr_en   <= wr_en_n;
      bus.wr_addr <= wr_addr_n;
      bus.wr_data <= wr_data_n;
      emit_adv    <= adv_n;
      drop        <= drop_n;
    end
  end

endmodule
